// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-8 generator/checker pair.
// Polynomial x^8+x^6+x^5+x+1; the stream obeys s[n]=s[n-2]^s[n-3]^s[n-7]^s[n-8].
package prbs_pkg;

   // Bit i of TAP set means hist[i] (bit s[n-1-i]) feeds the prediction.
   localparam logic [7:0] TAP         = 8'b1100_0110;
   localparam int         PRBS_PERIOD = 255;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_e;

   function automatic logic prbs_pred(input logic [7:0] hist);
      return ^(hist & TAP);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-8 checker: HUNT fills history, SYNC proves the
// received stream, LOCKED flywheels a local prediction and counts bit errors.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_THR = 4,
   parameter int LOSS_WIN = 16,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_CNT);
   localparam logic [7:0] LOSS_THR_C = 8'(LOSS_THR);
   localparam logic [7:0] LOSS_WIN_C = 8'(LOSS_WIN);

   state_e     state_q,    state_d;
   logic [7:0] hist_q,     hist_d;
   logic [3:0] fill_q,     fill_d;
   logic [7:0] sync_cnt_q, sync_cnt_d;
   logic [7:0] loss_cnt_q, loss_cnt_d;
   logic [7:0] good_run_q, good_run_d;
   logic       locked_q,   locked_d;
   logic       err_q,      err_d;
   logic       pred_s;
   logic       match_s;
   logic       err_inc_s;

   assign pred_s    = prbs_pred(hist_q);
   assign match_s   = (din == pred_s);
   assign err_inc_s = en && (state_q == LOCKED) && !match_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         hist_q     <= 8'd0;
         fill_q     <= 4'd0;
         sync_cnt_q <= 8'd0;
         loss_cnt_q <= 8'd0;
         good_run_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         hist_q     <= hist_d;
         fill_q     <= fill_d;
         sync_cnt_q <= sync_cnt_d;
         loss_cnt_q <= loss_cnt_d;
         good_run_q <= good_run_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      sync_cnt_d = sync_cnt_q;
      loss_cnt_d = loss_cnt_q;
      good_run_d = good_run_q;
      if (en) begin
         case (state_q)
            HUNT: begin
               hist_d     = {hist_q[6:0], din};
               fill_d     = (fill_q == 4'd8) ? 4'd8 : (fill_q + 4'd1);
               sync_cnt_d = 8'd0;
               if ((fill_d == 4'd8) && (hist_d != 8'd0)) begin
                  state_d = SYNC;
               end else begin
                  state_d = HUNT;
               end
            end
            SYNC: begin
               // Shift the received bit so a wrong seed gets replaced by real data.
               hist_d = {hist_q[6:0], din};
               if (hist_d == 8'd0) begin
                  state_d    = HUNT;
                  fill_d     = 4'd8;
                  sync_cnt_d = 8'd0;
               end else if (!match_s) begin
                  sync_cnt_d = 8'd0;
               end else if ((sync_cnt_q + 8'd1) == LOCK_CNT_C) begin
                  state_d    = LOCKED;
                  sync_cnt_d = 8'd0;
                  loss_cnt_d = 8'd0;
                  good_run_d = 8'd0;
               end else begin
                  sync_cnt_d = sync_cnt_q + 8'd1;
               end
            end
            LOCKED: begin
               // Flywheel: the prediction, not din, feeds history.
               hist_d = {hist_q[6:0], pred_s};
               if (!match_s) begin
                  good_run_d = 8'd0;
                  if ((loss_cnt_q + 8'd1) == LOSS_THR_C) begin
                     state_d    = HUNT;
                     fill_d     = 4'd0;
                     sync_cnt_d = 8'd0;
                     loss_cnt_d = 8'd0;
                  end else begin
                     loss_cnt_d = loss_cnt_q + 8'd1;
                  end
               end else if ((good_run_q + 8'd1) == LOSS_WIN_C) begin
                  good_run_d = 8'd0;
                  loss_cnt_d = 8'd0;
               end else begin
                  good_run_d = good_run_q + 8'd1;
               end
            end
            default: begin
               state_d = HUNT;
               fill_d  = 4'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      locked_d = (state_d == LOCKED);
      err_d    = err_inc_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign locked = locked_q;
   assign err    = err_q;

   sat_counter #(
      .W(CNT_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (err_inc_s),
      .clr  (clr),
      .cnt  (err_cnt)
   );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a default instance and a CNT_W=4,
// LOSS_THR=255 instance share one stimulus stream from a Galois PRBS-8 model.
module tb_prbs_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        din;
   logic        clr;
   logic        locked_a;
   logic        err_a;
   logic [15:0] err_cnt_a;
   logic        locked_b;
   logic        err_b;
   logic [3:0]  err_cnt_b;
   logic [7:0]  g;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   prbs_checker #(.LOCK_CNT(16), .LOSS_THR(4), .LOSS_WIN(16), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
      .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a)
   );

   prbs_checker #(.LOCK_CNT(16), .LOSS_THR(255), .LOSS_WIN(16), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
      .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b)
   );

   // Galois generator: emit q[7], then shift left folding taps 0,1,5,6.
   task automatic gen_bit(output logic b);
      b = g[7];
      g = {g[6:0], 1'b0} ^ (g[7] ? 8'h63 : 8'h00);
   endtask

   task automatic step(input logic e, input logic d, input logic c);
      en  = e;
      din = d;
      clr = c;
      @(posedge clk);
      #1;
      en  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic feed_clean();
      logic b;
      gen_bit(b);
      step(1'b1, b, 1'b0);
   endtask

   task automatic feed_bad(input logic c);
      logic b;
      gen_bit(b);
      step(1'b1, ~b, c);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic lock_up();
      g = 8'h01;
      repeat (24) feed_clean();
   endtask

   task automatic run_until_lock(output int n);
      n = 0;
      while (!locked_a && (n < 100)) begin
         feed_clean();
         n++;
      end
      if (!locked_a) n = 999;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b0; din = 1'b0; clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL reset_locked_a: got %b expected 0", locked_a); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b expected 0", err_a); end
      checks++; if (err_cnt_a !== 16'd0) begin errors++; $display("FAIL reset_err_cnt_a: got %0d expected 0", err_cnt_a); end
      checks++; if (err_cnt_b !== 4'd0) begin errors++; $display("FAIL reset_err_cnt_b: got %0d expected 0", err_cnt_b); end
      rst_n = 1'b1;
      repeat (30) step(1'b0, 1'b1, 1'b0);
      checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL en_low_no_lock: got %b expected 0", locked_a); end
   endtask

   task automatic test_lock();
      int lock_a = 0;
      int lock_b = 0;
      int errs = 0;
      do_reset();
      g = 8'h01;
      for (int i = 1; i <= 1000; i++) begin
         feed_clean();
         if (locked_a && (lock_a == 0)) lock_a = i;
         if (locked_b && (lock_b == 0)) lock_b = i;
         if (err_a || err_b) errs++;
      end
      checks++; if (lock_a !== 24) begin errors++; $display("FAIL lock_latency_a: got %0d expected 24", lock_a); end
      checks++; if (lock_b !== 24) begin errors++; $display("FAIL lock_latency_b: got %0d expected 24", lock_b); end
      checks++; if (errs !== 0) begin errors++; $display("FAIL clean_err_pulses: got %0d expected 0", errs); end
      checks++; if (err_cnt_a !== 16'd0) begin errors++; $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt_a); end
      checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL clean_still_locked: got %b expected 1", locked_a); end
   endtask

   task automatic test_single_error();
      int errs = 0;
      feed_bad(1'b0);
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL single_err_pulse: got %b expected 1", err_a); end
      checks++; if (err_cnt_a !== 16'd1) begin errors++; $display("FAIL single_err_cnt: got %0d expected 1", err_cnt_a); end
      checks++; if (locked_a !== 1'b1) begin errors++; $display("FAIL single_err_locked: got %b expected 1", locked_a); end
      for (int i = 0; i < 30; i++) begin
         feed_clean();
         if (err_a) errs++;
      end
      checks++; if (errs !== 0) begin errors++; $display("FAIL single_err_aftermath: got %0d pulses expected 0", errs); end
      checks++; if (err_cnt_a !== 16'd1) begin errors++; $display("FAIL single_err_cnt_hold: got %0d expected 1", err_cnt_a); end
   endtask

   task automatic test_loss();
      int n;
      do_reset();
      lock_up();
      for (int k = 1; k <= 4; k++) begin
         feed_bad(1'b0);
         checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL loss_err_pulse_%0d: got %b expected 1", k, err_a); end
         checks++; if (locked_a !== (k < 4)) begin errors++; $display("FAIL loss_locked_%0d: got %b expected %b", k, locked_a, (k < 4)); end
      end
      checks++; if (err_cnt_a !== 16'd4) begin errors++; $display("FAIL loss_err_cnt: got %0d expected 4", err_cnt_a); end
      checks++; if (locked_b !== 1'b1) begin errors++; $display("FAIL loss_b_locked: got %b expected 1", locked_b); end
      checks++; if (err_cnt_b !== 4'd4) begin errors++; $display("FAIL loss_b_err_cnt: got %0d expected 4", err_cnt_b); end
      run_until_lock(n);
      checks++; if (n !== 24) begin errors++; $display("FAIL relock_latency: got %0d expected 24", n); end
      checks++; if (err_cnt_a !== 16'd4) begin errors++; $display("FAIL relock_err_cnt_kept: got %0d expected 4", err_cnt_a); end
   endtask

   task automatic test_dead_line();
      int locks = 0;
      int errs = 0;
      int n;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (locked_a || locked_b) locks++;
         if (err_a || err_b) errs++;
      end
      checks++; if (locks !== 0) begin errors++; $display("FAIL dead_line_lock: got %0d cycles expected 0", locks); end
      checks++; if (errs !== 0) begin errors++; $display("FAIL dead_line_err: got %0d pulses expected 0", errs); end
      g = 8'h01;
      run_until_lock(n);
      checks++; if (n !== 24) begin errors++; $display("FAIL dead_line_lock_latency: got %0d expected 24", n); end
   endtask

   task automatic test_saturation();
      do_reset();
      lock_up();
      for (int k = 0; k < 20; k++) begin
         repeat (19) feed_clean();
         feed_bad(1'b0);
      end
      checks++; if (err_cnt_b !== 4'd15) begin errors++; $display("FAIL sat_err_cnt_b: got %0d expected 15", err_cnt_b); end
      checks++; if (locked_b !== 1'b1) begin errors++; $display("FAIL sat_locked_b: got %b expected 1", locked_b); end
      checks++; if (err_cnt_a !== 16'd20) begin errors++; $display("FAIL sat_err_cnt_a: got %0d expected 20", err_cnt_a); end
      feed_clean();
      step(1'b0, 1'b0, 1'b1);
      checks++; if (err_cnt_b !== 4'd0) begin errors++; $display("FAIL clr_err_cnt_b: got %0d expected 0", err_cnt_b); end
      feed_bad(1'b0);
      checks++; if (err_cnt_b !== 4'd1) begin errors++; $display("FAIL post_clr_count: got %0d expected 1", err_cnt_b); end
      feed_bad(1'b1);
      checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL clr_vs_err_pulse: got %b expected 1", err_b); end
      checks++; if (err_cnt_b !== 4'd0) begin errors++; $display("FAIL clr_vs_err_cnt: got %0d expected 0", err_cnt_b); end
   endtask

   task automatic test_en_toggle_and_reset();
      int n_en = 0;
      int lock_en = 0;
      int errs = 0;
      int n;
      do_reset();
      g = 8'h01;
      for (int cyc = 1; cyc <= 120; cyc++) begin
         if (cyc % 2 == 1) begin
            feed_clean();
            n_en++;
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
         if (err_a) errs++;
         if (locked_a && (lock_en == 0)) lock_en = n_en;
      end
      checks++; if (lock_en !== 24) begin errors++; $display("FAIL en_toggle_lock: got %0d expected 24", lock_en); end
      checks++; if (errs !== 0) begin errors++; $display("FAIL en_toggle_err: got %0d expected 0", errs); end
      feed_bad(1'b0);
      checks++; if (err_cnt_a !== 16'd1) begin errors++; $display("FAIL pre_reset_err_cnt: got %0d expected 1", err_cnt_a); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (locked_a !== 1'b0) begin errors++; $display("FAIL async_rst_locked: got %b expected 0", locked_a); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %b expected 0", err_a); end
      checks++; if (err_cnt_a !== 16'd0) begin errors++; $display("FAIL async_rst_err_cnt: got %0d expected 0", err_cnt_a); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_until_lock(n);
      checks++; if (n !== 24) begin errors++; $display("FAIL post_reset_relock: got %0d expected 24", n); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_single_error();
      test_loss();
      test_dead_line();
      test_saturation();
      test_en_toggle_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS-8 checker: the receive-side counterpart of the team's 8-bit Galois LFSR pattern generator. Takes the generator's output bit stream, self-synchronises to it, declares lock, and from then on counts bit errors against a free-running local prediction (flywheel). Sits at the link/loopback test endpoint, fed one bit per enabled cycle.

## Interface
- LOCK_CNT, 16, consecutive correct predictions required in SYNC before declaring lock (1..255)
- LOSS_THR, 4, errors within a loss window that force loss of lock (1..255)
- LOSS_WIN, 16, consecutive correct bits that clear the loss counter (1..255)
- CNT_W, 16, width of the error counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  din valid this cycle; all state holds when low
- din  in  1  received bit: the generator's q[7] taken each generator step
- clr  in  1  synchronous clear of err_cnt only
- locked  out  1  registered, high while in LOCKED
- err  out  1  registered one-cycle pulse per mismatched bit while LOCKED
- err_cnt  out  CNT_W  saturating count of mismatches while LOCKED

## Operation
- Polynomial P(x)=x^8+x^6+x^5+x+1, primitive, period 255, matching the generator's taps into bits 0,1,5,6. Output stream obeys s[n]=s[n-2]^s[n-3]^s[n-7]^s[n-8].
- hist[7:0] holds the last 8 bits, hist[0]=newest. pred = hist[1]^hist[2]^hist[6]^hist[7].
- States: HUNT, SYNC, LOCKED. Reset state HUNT.
- HUNT: each en shifts din into hist and increments fill (0..8). When fill reaches 8 and the new hist is nonzero -> SYNC. If hist is all-zero, stay in HUNT with fill held at 8.
- SYNC: each en compares din to pred, then shifts din (received, not predicted) into hist. On match, sync_cnt++. When sync_cnt reaches LOCK_CNT -> LOCKED. On mismatch, sync_cnt=0 and stay in SYNC. An all-zero hist after the shift -> HUNT with fill=8. This blocks lock on a dead (all-zero) line.
- LOCKED: each en compares din to pred and shifts pred (flywheel) into hist, so one flipped bit gives exactly one error.
  - On mismatch: err pulse; err_cnt++ saturating at 2^CNT_W-1; loss_cnt++; good_run=0.
  - On match: good_run++. When good_run reaches LOSS_WIN, loss_cnt=0 and good_run=0.
  - When loss_cnt reaches LOSS_THR -> HUNT with fill=0, sync_cnt=0, loss_cnt=0.
- err_cnt counts only in LOCKED. It is not cleared on loss of lock. It is cleared only by clr or reset.
- clr and an error in the same cycle: clr wins, giving err_cnt=0.
- en low: no shift, no counting, err=0.

## Timing
- Reset (async) values: locked=0, err=0, err_cnt=0. hist, fill, sync_cnt, loss_cnt and good_run are all 0. State is HUNT.
- err is asserted in the cycle after the en cycle carrying the bad bit.
- locked changes in the cycle after the deciding en cycle.
- With a clean stream and en every cycle, locked rises after 8+LOCK_CNT en bits.
- Loss takes effect on the LOSS_THR-th error. locked falls in the same cycle that the final err pulse is visible.
- rst_n low mid-operation clears everything immediately. Relock after reset requires a full HUNT+SYNC.

## Structure
- Shared package prbs_pkg holds:
  - TAP constant 8'b1100_0110, the hist positions feeding pred;
  - the state enum {HUNT, SYNC, LOCKED};
  - PRBS_PERIOD=255.
- The generator should import the same package.
- One sub-module: sat_counter (parameter W; inputs inc, clr; saturating output), used for err_cnt.
- All other logic stays flat in prbs_checker.

## Test plan
- Generator seeded at state 8'b0000_0001, en=1 continuously, default params -> locked=1 after exactly 24 bits; err never asserts over 1000 bits; err_cnt=0.
- Lock established, then one bit inverted -> exactly one err pulse, err_cnt=1, locked stays 1. Next 30 clean bits give no further err.
- Lock established, then 4 consecutive inverted bits -> 4 err pulses, err_cnt=4, locked=0 in the cycle after the 4th en. Clean stream afterwards -> locked=1 after 24 further bits, and err_cnt is still 4.
- din tied 0 for 500 cycles -> locked never asserts, err never asserts. Switching to a clean stream -> lock after at most 24 nonzero-history bits.
- CNT_W=4, LOSS_THR=255: lock, then invert every 20th bit 20 times -> err_cnt saturates at 15. clr pulse -> 0. clr coincident with an error -> 0.
- en toggling 1/0 with a clean stream -> lock after 24 enabled bits (48 cycles). rst_n pulsed low mid-lock -> locked, err and err_cnt are 0 asynchronously, and relock takes 24 bits.
